// File: rtl/rr_mux4_feeder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : rr_mux4_feeder_pkg                                         |
// | Purpose : Shared definitions for the round-robin 4:1 mux feeder:     |
// |           channel count, select width and FSM state encoding.        |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package rr_mux4_feeder_pkg;

  localparam int NUM_CH = 4;
  localparam int SEL_W  = 2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

endpackage : rr_mux4_feeder_pkg
`default_nettype wire

// File: rtl/rr_mux4_feeder_rr_pick4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_pick4                                                   |
// | Purpose : Combinational round-robin picker. Scans req starting at    |
// |           ptr (ptr, ptr+1, ... mod 4) and returns the first set bit, |
// |           optionally skipping one excluded channel.                  |
// | Ports   : req[3:0]      in  request vector                           |
// |           ptr[1:0]      in  first channel to examine                 |
// |           excl_en       in  enable exclusion of excl_idx             |
// |           excl_idx[1:0] in  channel to skip when excl_en is high     |
// |           any           out a non-excluded request was found         |
// |           idx[1:0]      out winning channel (valid when any=1)       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_pick4
  import rr_mux4_feeder_pkg::*;
(
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              excl_en,
  input  logic [SEL_W-1:0]  excl_idx,
  output logic              any,
  output logic [SEL_W-1:0]  idx
);

  logic [SEL_W-1:0] cand;

  // Walk from the farthest offset back to offset 0 so the candidate
  // closest to ptr is the last one written and therefore wins.
  always_comb begin
    any  = 1'b0;
    idx  = ptr;
    cand = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand] && !(excl_en && (cand == excl_idx))) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_mux4_feeder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : rr_mux4_feeder                                             |
// | Purpose : Round-robin scheduler in front of a combinational 4:1 mux. |
// |           Grants one requesting channel at a time (drives sel/gnt),  |
// |           samples the mux output z into a registered valid/ready     |
// |           stream, limits each grant to HOLD_MAX samples.             |
// | Ports   : clk, rst (sync, active high)                               |
// |           req[3:0]    in  per-channel request                        |
// |           z           in  mux output (depends on sel)                |
// |           dout_ready  in  downstream accepts dout                    |
// |           sel[1:0]    out registered mux select                      |
// |           gnt[3:0]    out registered one-hot grant, 0 when idle      |
// |           dout        out registered sample of z                     |
// |           dout_valid  out dout holds an unaccepted sample            |
// |           busy        out high while in the GRANT state              |
// |           grant_cnt   out per-channel 8-bit saturating grant counts  |
// |                           (only when RR_MUX4_STATS_EN is defined)    |
// | Macro   : RR_MUX4_STATS_EN - adds the grant_cnt statistics port      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module rr_mux4_feeder
  import rr_mux4_feeder_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              z,
  input  logic              dout_ready,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] gnt,
  output logic              dout,
  output logic              dout_valid,
  output logic              busy
`ifdef RR_MUX4_STATS_EN
  ,
  output logic [31:0]       grant_cnt
`endif
);

  state_e            state_q, state_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  hold_q, hold_d;
  logic              dout_q, dout_d;
  logic              dout_valid_q, dout_valid_d;
  logic              busy_q, busy_d;

  logic              stalled;
  logic              req_cur;
  logic              release_now;
  logic              grant_start;
  logic [SEL_W-1:0]  grant_idx;

  logic              pick_any;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  pick_ptr;
  logic              pick_excl;

  // In IDLE the scan starts at ptr; on release it starts just past the
  // current channel and skips it, so the current channel is only
  // re-granted when nobody else is asking.
  assign pick_ptr  = (state_q == ST_IDLE) ? ptr_q : sel_q + SEL_W'(1);
  assign pick_excl = (state_q == ST_GRANT);

  rr_pick4 u_pick (
    .req      (req),
    .ptr      (pick_ptr),
    .excl_en  (pick_excl),
    .excl_idx (sel_q),
    .any      (pick_any),
    .idx      (pick_idx)
  );

  assign stalled     = dout_valid_q & ~dout_ready;
  assign req_cur     = req[sel_q];
  assign release_now = ~req_cur | (hold_q == CNT_W'(HOLD_MAX - 1));

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    gnt_d        = gnt_q;
    ptr_d        = ptr_q;
    hold_d       = hold_q;
    dout_d       = dout_q;
    busy_d       = busy_q;
    // Accepted samples drop out; a stall keeps the sample in place.
    dout_valid_d = dout_valid_q & ~dout_ready;
    grant_start  = 1'b0;
    grant_idx    = pick_idx;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_GRANT;
          sel_d       = pick_idx;
          gnt_d       = NUM_CH'(1) << pick_idx;
          hold_d      = '0;
          busy_d      = 1'b1;
          grant_start = 1'b1;
        end
      end

      ST_GRANT: begin
        // While stalled nothing moves, including release decisions.
        if (!stalled) begin
          if (req_cur) begin
            dout_d       = z;
            dout_valid_d = 1'b1;
            hold_d       = hold_q + CNT_W'(1);
          end
          if (release_now) begin
            ptr_d  = sel_q + SEL_W'(1);
            hold_d = '0;
            if (pick_any) begin
              sel_d       = pick_idx;
              gnt_d       = NUM_CH'(1) << pick_idx;
              grant_start = 1'b1;
            end else if (req_cur) begin
              // Hold expired with no competitor: fresh grant, same channel.
              grant_idx   = sel_q;
              grant_start = 1'b1;
            end else begin
              state_d = ST_IDLE;
              gnt_d   = '0;
              busy_d  = 1'b0;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      gnt_q        <= '0;
      ptr_q        <= '0;
      hold_q       <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      gnt_q        <= gnt_d;
      ptr_q        <= ptr_d;
      hold_q       <= hold_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign sel        = sel_q;
  assign gnt        = gnt_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = busy_q;

`ifdef RR_MUX4_STATS_EN
  for (genvar i = 0; i < NUM_CH; i++) begin : g_stat_cnt
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (grant_start && (grant_idx == SEL_W'(i)) && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q <= 8'd0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign grant_cnt[8*i +: 8] = cnt_q;
  end
`else
  logic unused_stats;
  assign unused_stats = ^{grant_start, grant_idx};
`endif

endmodule : rr_mux4_feeder
`default_nettype wire
